// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store engine.
package mem_access_unit_pkg;

  localparam int MEM_LANES = 8;

  typedef logic [63:0] data_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_width_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_fsm_enum;

  // Byte-lane enables for an access of the given width starting at lane 0.
  function automatic logic [MEM_LANES-1:0] width_mask(input mem_width_enum w);
    logic [MEM_LANES-1:0] m;
    case (w)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      MEM_D:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Natural alignment check on the byte offset within the 8-byte word.
  function automatic logic is_aligned(input logic [2:0] off, input mem_width_enum w);
    logic ok;
    case (w)
      MEM_B:   ok = 1'b1;
      MEM_H:   ok = (off[0] == 1'b0);
      MEM_W:   ok = (off[1:0] == 2'b00);
      MEM_D:   ok = (off == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_data_align.sv
// Combinational lane steering: store mask/data placement, load extraction
// with sign/zero extension, and misalignment detection.
module mem_data_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]     st_off,
  input  mem_width_enum  st_width,
  input  logic [63:0]    st_data,
  output logic [7:0]     st_wmask,
  output logic [63:0]    st_wdata,
  output logic           misaligned,
  input  logic [63:0]    ld_rdata,
  input  logic [2:0]     ld_off,
  input  mem_width_enum  ld_width,
  input  logic           ld_unsigned,
  output logic [63:0]    ld_result
);

  logic [63:0] ld_shifted;

  // Store side: place mask and data onto the lanes selected by the offset.
  always_comb begin
    st_wmask   = width_mask(st_width) << st_off;
    st_wdata   = st_data << {st_off, 3'b000};
    misaligned = ~is_aligned(st_off, st_width);
  end

  // Load side: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_result  = 64'd0;
    case (ld_width)
      MEM_B: begin
        if (ld_unsigned) ld_result = {56'd0, ld_shifted[7:0]};
        else             ld_result = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      end
      MEM_H: begin
        if (ld_unsigned) ld_result = {48'd0, ld_shifted[15:0]};
        else             ld_result = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      end
      MEM_W: begin
        if (ld_unsigned) ld_result = {32'd0, ld_shifted[31:0]};
        else             ld_result = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      end
      MEM_D:   ld_result = ld_shifted;
      default: ld_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one valid/ready request plus one response per
// access, stalling the pipeline until the result is available in DONE.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              re_mem,
  input  logic              we_mem,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] data_package,
  input  logic [1:0]        memdata_width,
  input  logic              mem_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [DATA_W-1:0] mem_trunc,
  output logic              mem_stall,
  output logic              misalign
);

  mem_fsm_enum   state_r, state_next;
  mem_width_enum in_width;
  logic          start;
  logic          issue;
  logic          bad_align;
  logic [7:0]    lane_mask;
  logic [63:0]   lane_wdata;
  logic [63:0]   load_value;

  logic          req_valid_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic          req_wen_r;
  logic [63:0]   req_wdata_r;
  logic [7:0]    req_wmask_r;
  logic [2:0]    off_r;
  mem_width_enum width_r;
  logic          unsigned_r;
  logic          load_r;
  logic [63:0]   trunc_r;

  assign in_width = mem_width_enum'(memdata_width);
  assign start    = mem_valid & (re_mem | we_mem);

  mem_data_align u_align (
    .st_off      (alu_res[2:0]),
    .st_width    (in_width),
    .st_data     (data_package),
    .st_wmask    (lane_mask),
    .st_wdata    (lane_wdata),
    .misaligned  (bad_align),
    .ld_rdata    (mem_resp_rdata),
    .ld_off      (off_r),
    .ld_width    (width_r),
    .ld_unsigned (unsigned_r),
    .ld_result   (load_value)
  );

  // Next-state, stall and misalignment pulse.
  always_comb begin
    state_next = state_r;
    mem_stall  = 1'b0;
    misalign   = 1'b0;
    issue      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (bad_align) begin
            misalign   = 1'b1;
            state_next = IDLE;
          end else begin
            mem_stall  = 1'b1;
            issue      = 1'b1;
            state_next = REQ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (mem_req_ready) state_next = WAIT;
        else               state_next = REQ;
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (mem_resp_valid) state_next = DONE;
        else                state_next = WAIT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next;
  end

  // Request registers: captured once when an aligned access is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_r <= 1'b0;
      req_addr_r  <= '0;
      req_wen_r   <= 1'b0;
      req_wdata_r <= 64'd0;
      req_wmask_r <= 8'd0;
      off_r       <= 3'd0;
      width_r     <= MEM_B;
      unsigned_r  <= 1'b0;
      load_r      <= 1'b0;
    end else begin
      req_valid_r <= (state_next == REQ);
      if (issue) begin
        req_addr_r  <= {alu_res[ADDR_W-1:3], 3'b000};
        req_wen_r   <= we_mem;
        req_wdata_r <= lane_wdata;
        req_wmask_r <= we_mem ? lane_mask : 8'd0;
        off_r       <= alu_res[2:0];
        width_r     <= in_width;
        unsigned_r  <= mem_unsigned;
        load_r      <= re_mem;
      end
    end
  end

  // Result register: updated only when the response arrives in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trunc_r <= 64'd0;
    end else if (state_r == WAIT && mem_resp_valid) begin
      trunc_r <= load_r ? load_value : 64'd0;
    end
  end

  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = req_addr_r;
  assign mem_req_wen   = req_wen_r;
  assign mem_req_wdata = req_wdata_r;
  assign mem_req_wmask = req_wmask_r;
  assign mem_trunc     = trunc_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a behavioural memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, re_mem, we_mem;
  logic [63:0] alu_res, data_package;
  logic [1:0]  memdata_width;
  logic        mem_unsigned;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic [63:0] mem_trunc;
  logic        mem_stall, misalign;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] model_trunc = 64'd0;

  typedef struct {
    logic        re;
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  width;
    logic        uns;
    logic [63:0] rdata;
    logic        bad;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] trunc;
  } vec_t;

  vec_t vecs[16];

  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .re_mem(re_mem), .we_mem(we_mem),
    .alu_res(alu_res), .data_package(data_package), .memdata_width(memdata_width),
    .mem_unsigned(mem_unsigned), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .mem_trunc(mem_trunc), .mem_stall(mem_stall),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one access; the memory accepts after rdly extra cycles and responds
  // sdly cycles after the first WAIT cycle.
  task automatic run_op(input vec_t v, input int rdly, input int sdly);
    int vcnt;
    @(negedge clk);
    mem_valid = 1'b1; re_mem = v.re; we_mem = v.we; alu_res = v.addr;
    data_package = v.data; memdata_width = v.width; mem_unsigned = v.uns;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = v.rdata;
    #1;
    if (v.bad) begin
      check("misalign_pulse", {63'd0, misalign}, 64'd1);
      check("misalign_stall", {63'd0, mem_stall}, 64'd0);
      check("misalign_reqv", {63'd0, mem_req_valid}, 64'd0);
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      check("misalign_clear", {63'd0, misalign}, 64'd0);
      check("misalign_noreq", {63'd0, mem_req_valid}, 64'd0);
      check("misalign_trunc", mem_trunc, model_trunc);
    end else begin
      check("idle_stall", {63'd0, mem_stall}, 64'd1);
      check("idle_misalign", {63'd0, misalign}, 64'd0);
      vcnt = 0;
      for (int i = 0; i <= rdly; i++) begin
        @(negedge clk); #1;
        if (mem_req_valid) vcnt++;
        check("req_stall", {63'd0, mem_stall}, 64'd1);
        if (i == 0) begin
          check("req_addr", mem_req_addr, v.addr & ~64'h7);
          check("req_wen", {63'd0, mem_req_wen}, {63'd0, v.we});
          check("req_wmask", {56'd0, mem_req_wmask}, {56'd0, v.wmask});
          if (v.we) check("req_wdata", mem_req_wdata, v.wdata);
        end
        mem_req_ready = (i == rdly);
      end
      check("req_valid_cycles", 64'(vcnt), 64'(rdly + 1));
      for (int j = 0; j <= sdly; j++) begin
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("wait_reqv", {63'd0, mem_req_valid}, 64'd0);
        check("wait_stall", {63'd0, mem_stall}, 64'd1);
        mem_resp_valid = (j == sdly);
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      check("done_stall", {63'd0, mem_stall}, 64'd0);
      check("done_trunc", mem_trunc, v.trunc);
      model_trunc = v.trunc;
      mem_valid = 1'b0;
    end
  endtask

  initial begin
    //          re    we    addr          data                    w     uns   rdata                   bad   wmask  wdata                   trunc
    vecs[0]  = '{1'b1, 1'b0, 64'h1003, 64'h0,                2'd0, 1'b0, 64'h11223344_80667788, 1'b0, 8'h00, 64'h0,                64'hFFFFFFFF_FFFFFF80};
    vecs[1]  = '{1'b1, 1'b0, 64'h1003, 64'h0,                2'd0, 1'b1, 64'h11223344_80667788, 1'b0, 8'h00, 64'h0,                64'h00000000_00000080};
    vecs[2]  = '{1'b0, 1'b1, 64'h2006, 64'h12345678_9ABCABCD, 2'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'hC0, 64'hABCD0000_00000000, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 64'h2002, 64'h0,                2'd2, 1'b0, 64'h0,                1'b1, 8'h00, 64'h0,                64'h0};
    vecs[4]  = '{1'b1, 1'b0, 64'h100A, 64'h0,                2'd1, 1'b0, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'hFFFFFFFF_FFFF89AB};
    vecs[5]  = '{1'b1, 1'b0, 64'h100A, 64'h0,                2'd1, 1'b1, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'h00000000_000089AB};
    vecs[6]  = '{1'b1, 1'b0, 64'h1004, 64'h0,                2'd2, 1'b0, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'h00000000_01234567};
    vecs[7]  = '{1'b1, 1'b0, 64'h1000, 64'h0,                2'd2, 1'b0, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'hFFFFFFFF_89ABCDEF};
    vecs[8]  = '{1'b1, 1'b0, 64'h1000, 64'h0,                2'd2, 1'b1, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'h00000000_89ABCDEF};
    vecs[9]  = '{1'b1, 1'b0, 64'h1008, 64'h0,                2'd3, 1'b0, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'h01234567_89ABCDEF};
    vecs[10] = '{1'b0, 1'b1, 64'h3005, 64'h00000000_0055AAEE, 2'd0, 1'b0, 64'h12345678_12345678, 1'b0, 8'h20, 64'h55AAEE00_00000000, 64'h0};
    vecs[11] = '{1'b0, 1'b1, 64'h3004, 64'hDEADBEEF_CAFEF00D, 2'd2, 1'b0, 64'h12345678_12345678, 1'b0, 8'hF0, 64'hCAFEF00D_00000000, 64'h0};
    vecs[12] = '{1'b0, 1'b1, 64'h3008, 64'hDEADBEEF_CAFEF00D, 2'd3, 1'b0, 64'h12345678_12345678, 1'b0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 64'h0};
    vecs[13] = '{1'b0, 1'b1, 64'h3009, 64'hDEADBEEF_CAFEF00D, 2'd3, 1'b0, 64'h0,                1'b1, 8'h00, 64'h0,                64'h0};
    vecs[14] = '{1'b1, 1'b0, 64'h1001, 64'h0,                2'd1, 1'b0, 64'h0,                1'b1, 8'h00, 64'h0,                64'h0};
    vecs[15] = '{1'b1, 1'b0, 64'h1007, 64'h0,                2'd0, 1'b0, 64'h01234567_89ABCDEF, 1'b0, 8'h00, 64'h0,                64'h00000000_00000001};

    rst = 1'b1; mem_valid = 1'b0; re_mem = 1'b0; we_mem = 1'b0; alu_res = 64'd0;
    data_package = 64'd0; memdata_width = 2'd0; mem_unsigned = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_reqv", {63'd0, mem_req_valid}, 64'd0);
    check("rst_stall", {63'd0, mem_stall}, 64'd0);
    check("rst_misalign", {63'd0, misalign}, 64'd0);
    check("rst_trunc", mem_trunc, 64'd0);
    check("rst_wmask", {56'd0, mem_req_wmask}, 64'd0);
    check("rst_addr", mem_req_addr, 64'd0);
    rst = 1'b0;

    // Single accesses with a one-cycle memory.
    for (int k = 0; k < 16; k++) run_op(vecs[k], 0, 0);

    // Slow memory: ready after 4 waiting cycles, response 2 cycles later.
    run_op(vecs[0], 0, 0);
    run_op(vecs[9], 4, 1);

    // Back-to-back load then store.
    run_op(vecs[7], 0, 0);
    run_op(vecs[12], 0, 0);

    // Reset while waiting for a response, then a late response.
    run_op(vecs[0], 0, 0);
    @(negedge clk);
    mem_valid = 1'b1; re_mem = 1'b1; we_mem = 1'b0; alu_res = 64'h4000;
    memdata_width = 2'd3; mem_unsigned = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("pre_rst_wait_stall", {63'd0, mem_stall}, 64'd1);
    rst = 1'b1; mem_valid = 1'b0;
    #1;
    check("midrst_reqv", {63'd0, mem_req_valid}, 64'd0);
    check("midrst_stall", {63'd0, mem_stall}, 64'd0);
    check("midrst_trunc", mem_trunc, 64'd0);
    @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("late_resp_trunc", mem_trunc, 64'd0);
    check("late_resp_stall", {63'd0, mem_stall}, 64'd0);
    check("late_resp_reqv", {63'd0, mem_req_valid}, 64'd0);
    model_trunc = 64'd0;
    run_op(vecs[9], 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
